// File: rtl/float32_arb_pkg.sv
// Shared types and widths for the two-requester float32 adder arbiter.
package float32_arb_pkg;

    localparam int unsigned FP32_W = 32;
    localparam int unsigned ID_W   = 1;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

endpackage

// File: rtl/float32_adder.sv
// Combinational IEEE-754 single-precision adder, round-to-nearest-even.
// Subnormal inputs are treated as zero and underflowing results flush to signed zero.
module float32_adder
    import float32_arb_pkg::*;
(
    input  logic [FP32_W-1:0] a,
    input  logic [FP32_W-1:0] b,
    output logic [FP32_W-1:0] sum
);

    logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic               swap;
    logic               sl, ss;
    logic [7:0]         el, es, diff;
    logic [23:0]        ml, ms;
    logic [49:0]        wide;
    logic [26:0]        al;
    logic [27:0]        raw;
    logic [26:0]        norm;
    logic [4:0]         lz;
    logic signed [9:0]  exp_n, exp_r;
    logic [24:0]        rnd;
    logic               inc;
    logic [22:0]        mant;

    always_comb begin
        a_zero = (a[30:23] == 8'h00);
        b_zero = (b[30:23] == 8'h00);
        a_inf  = (a[30:23] == 8'hff) && (a[22:0] == 23'd0);
        b_inf  = (b[30:23] == 8'hff) && (b[22:0] == 23'd0);
        a_nan  = (a[30:23] == 8'hff) && (a[22:0] != 23'd0);
        b_nan  = (b[30:23] == 8'hff) && (b[22:0] != 23'd0);

        swap = (b[30:0] > a[30:0]);
        sl   = swap ? b[31] : a[31];
        ss   = swap ? a[31] : b[31];
        el   = swap ? b[30:23] : a[30:23];
        es   = swap ? a[30:23] : b[30:23];
        ml   = {1'b1, (swap ? b[22:0] : a[22:0])};
        ms   = {1'b1, (swap ? a[22:0] : b[22:0])};
        diff = el - es;

        // Align the smaller operand keeping guard, round and a sticky bit.
        wide = {ms, 26'd0} >> diff;
        if (diff >= 8'd27) begin
            al = 27'd1;
        end else begin
            al = {wide[49:24], wide[23] | (|wide[22:0])};
        end

        if (sl == ss) begin
            raw = {1'b0, ml, 3'b000} + {1'b0, al};
        end else begin
            raw = {1'b0, ml, 3'b000} - {1'b0, al};
        end

        lz = 5'd0;
        for (int i = 0; i <= 26; i++) begin
            if (raw[i]) begin
                lz = 5'(26 - i);
            end
        end

        if (raw[27]) begin
            norm  = {raw[27:2], raw[1] | raw[0]};
            exp_n = $signed({2'b00, el}) + 10'sd1;
        end else begin
            norm  = raw[26:0] << lz;
            exp_n = $signed({2'b00, el}) - $signed({5'b00000, lz});
        end

        inc   = norm[2] & (norm[1] | norm[0] | norm[3]);
        rnd   = {1'b0, norm[26:3]} + {24'd0, inc};
        exp_r = rnd[24] ? exp_n + 10'sd1 : exp_n;
        mant  = rnd[24] ? rnd[23:1] : rnd[22:0];

        if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) begin
            sum = 32'h7fc0_0000;
        end else if (a_inf) begin
            sum = a;
        end else if (b_inf) begin
            sum = b;
        end else if (a_zero && b_zero) begin
            sum = {a[31] & b[31], 31'd0};
        end else if (a_zero) begin
            sum = b;
        end else if (b_zero) begin
            sum = a;
        end else if (raw == 28'd0) begin
            sum = 32'd0;
        end else if (exp_r <= 10'sd0) begin
            sum = {sl, 31'd0};
        end else if (exp_r >= 10'sd255) begin
            sum = {sl, 8'hff, 23'd0};
        end else begin
            sum = {sl, exp_r[7:0], mant};
        end
    end

endmodule

// File: rtl/float32_add_arbiter.sv
// Round-robin arbiter between two requesters sharing one float32 adder;
// one operation in flight, result held until the consumer takes it.
module float32_add_arbiter
    import float32_arb_pkg::*;
#(
    parameter int unsigned PRIO_INIT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [FP32_W-1:0] req0_a,
    input  logic [FP32_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [FP32_W-1:0] req1_a,
    input  logic [FP32_W-1:0] req1_b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [FP32_W-1:0] res_data,
    output logic              res_id,
    output logic              busy
);

    localparam logic PTR_INIT = PRIO_INIT[0];

    state_t            state;
    logic              ptr;
    logic [FP32_W-1:0] op_a, op_b, add_sum;
    logic [ID_W-1:0]   op_id;

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (state == IDLE && !rst) begin
            if (req0_valid && (!req1_valid || ptr == 1'b0)) begin
                req0_ready = 1'b1;
            end else if (req1_valid) begin
                req1_ready = 1'b1;
            end
        end
    end

    float32_adder u_adder (
        .a   (op_a),
        .b   (op_b),
        .sum (add_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= PTR_INIT;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= 1'b0;
            busy      <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            op_id     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req0_ready || req1_ready) begin
                        op_a  <= req1_ready ? req1_a : req0_a;
                        op_b  <= req1_ready ? req1_b : req0_b;
                        op_id <= req1_ready;
                        busy  <= 1'b1;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    res_data  <= add_sum;
                    res_id    <= op_id;
                    res_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    // Pointer moves only here, so withdrawn requests never disturb fairness.
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        ptr       <= ~res_id;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_float32_add_arbiter.sv
// Scoreboard bench: requester drivers push nothing; a negedge monitor models grants
// and sums from first principles and compares every DUT output cycle.
module tb_float32_add_arbiter;

    localparam int unsigned PRIO_INIT = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        res_valid, res_id, busy;
    logic        res_ready = 1'b1;
    logic [31:0] res_data;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic        id;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    logic        mdl_busy = 1'b0;
    logic        mdl_ptr  = 1'b0;
    int          mdl_age  = 0;
    logic        eg0, eg1;
    logic        id_hist[$];
    logic [31:0] data_hist[$];
    bit          rand_done = 1'b0;
    bit          ok0, ok1;

    always #5 clk = ~clk;

    float32_add_arbiter #(.PRIO_INIT(PRIO_INIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_id     (res_id),
        .busy       (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Exact sum as a scaled integer, then a single round-to-nearest-even to 24 bits.
    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        longint ma, mb, sm, mag, q, rem, half;
        int     ea, eb, emin, p, ex, sh;
        logic   s;
        ea   = int'(a[30:23]);
        eb   = int'(b[30:23]);
        emin = (ea < eb) ? ea : eb;
        ma   = {40'd0, 1'b1, a[22:0]};
        mb   = {40'd0, 1'b1, b[22:0]};
        ma   = ma <<< (ea - emin);
        mb   = mb <<< (eb - emin);
        if (a[31]) ma = -ma;
        if (b[31]) mb = -mb;
        sm = ma + mb;
        if (sm == 0) return 32'd0;
        s   = (sm < 0);
        mag = s ? -sm : sm;
        p   = 0;
        for (int i = 0; i < 63; i++) begin
            if (mag[i]) p = i;
        end
        ex = emin + p - 23;
        if (p > 23) begin
            sh   = p - 23;
            q    = mag >>> sh;
            rem  = mag - (q <<< sh);
            half = 64'sd1 <<< (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            if (q == (64'sd1 <<< 24)) begin
                q  = q >>> 1;
                ex = ex + 1;
            end
        end else begin
            q = mag <<< (23 - p);
        end
        return {s, 8'(ex), q[22:0]};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] v;
        v[31]    = 1'($urandom);
        v[30:23] = 8'(110 + $urandom % 36);
        v[22:0]  = 23'($urandom);
        return v;
    endfunction

    function automatic logic [31:0] rand_b(input logic [31:0] a);
        logic [31:0] v;
        int          k;
        v = rand_fp();
        k = int'($urandom % 8);
        if (k == 0) v = a ^ 32'h8000_0000;
        else if (k == 1) v[30:23] = a[30:23];
        return v;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            check("ready0_in_reset", 32'(req0_ready), 32'd0);
            check("ready1_in_reset", 32'(req1_ready), 32'd0);
            exp_q.delete();
            mdl_busy = 1'b0;
            mdl_ptr  = PRIO_INIT[0];
            mdl_age  = 0;
        end else begin
            check("busy", 32'(busy), 32'(mdl_busy));
            check("res_valid", 32'(res_valid), 32'(mdl_busy && mdl_age >= 1));
            if (mdl_busy && mdl_age >= 1 && res_valid && exp_q.size() != 0) begin
                check("res_data", res_data, exp_q[0].data);
                check("res_id", 32'(res_id), 32'(exp_q[0].id));
            end
            eg0 = !mdl_busy && req0_valid && (!req1_valid || mdl_ptr == 1'b0);
            eg1 = !mdl_busy && req1_valid && !eg0;
            check("req0_ready", 32'(req0_ready), 32'(eg0));
            check("req1_ready", 32'(req1_ready), 32'(eg1));
            if (mdl_busy) begin
                if (mdl_age >= 1 && res_ready) begin
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        mdl_ptr = ~e.id;
                    end
                    id_hist.push_back(res_id);
                    data_hist.push_back(res_data);
                    mdl_busy = 1'b0;
                end else begin
                    mdl_age++;
                end
            end else if (eg0 || eg1) begin
                e.id   = eg1;
                e.data = eg1 ? ref_add(req1_a, req1_b) : ref_add(req0_a, req0_b);
                exp_q.push_back(e);
                mdl_busy = 1'b1;
                mdl_age  = 0;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
    endtask

    // Presents one pair and holds valid until granted or max_wait cycles elapse.
    task automatic send(input int n, input logic [31:0] a, input logic [31:0] b,
                        input int max_wait, input bit must, output bit ok);
        if (n == 0) begin
            req0_a = a; req0_b = b; req0_valid = 1'b1;
        end else begin
            req1_a = a; req1_b = b; req1_valid = 1'b1;
        end
        ok = 1'b0;
        for (int i = 0; i < max_wait && !ok; i++) begin
            @(negedge clk);
            if ((n == 0) ? (req0_ready === 1'b1) : (req1_ready === 1'b1)) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        if (n == 0) req0_valid = 1'b0;
        else req1_valid = 1'b0;
        if (must && !ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL grant_timeout: requester %0d got no ready, expected one within %0d",
                     n, max_wait);
        end
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 200 && mdl_busy; i++) cyc(1);
        if (mdl_busy) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: block still busy, expected idle");
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin
        cyc(3);
        rst = 1'b0;
        @(negedge clk);
        check("reset_res_data", res_data, 32'd0);
        check("reset_res_id", 32'(res_id), 32'd0);
        cyc(1);

        // Single request
        send(0, 32'h4020_0000, 32'h4060_0000, 20, 1'b1, ok0);
        wait_idle();
        check("single_data", data_hist[data_hist.size()-1], 32'h40C0_0000);
        check("single_id", 32'(id_hist[id_hist.size()-1]), 32'd0);

        // Contention after reset
        do_reset();
        id_hist.delete(); data_hist.delete();
        fork
            send(0, 32'h3F80_0000, 32'h4000_0000, 20, 1'b1, ok0);
            send(1, 32'h4040_0000, 32'h4040_0000, 20, 1'b1, ok1);
        join
        wait_idle();
        check("contend_first_data", data_hist[0], 32'h4040_0000);
        check("contend_first_id", 32'(id_hist[0]), 32'd0);
        check("contend_second_data", data_hist[1], 32'h40C0_0000);
        check("contend_second_id", 32'(id_hist[1]), 32'd1);

        // Backpressure in DONE
        res_ready = 1'b0;
        send(0, rand_fp(), rand_fp(), 20, 1'b1, ok0);
        cyc(6);
        @(negedge clk);
        check("bp_busy", 32'(busy), 32'd1);
        check("bp_valid", 32'(res_valid), 32'd1);
        cyc(1);
        res_ready = 1'b1;
        wait_idle();

        // Fairness with both requesters continuously valid
        do_reset();
        id_hist.delete(); data_hist.delete();
        fork
            for (int k = 0; k < 3; k++) send(0, rand_fp(), rand_fp(), 30, 1'b1, ok0);
            for (int k = 0; k < 3; k++) send(1, rand_fp(), rand_fp(), 30, 1'b1, ok1);
        join
        wait_idle();
        check("fair_count", 32'(id_hist.size()), 32'd6);
        for (int k = 0; k < id_hist.size(); k++) check("fair_id", 32'(id_hist[k]), 32'(k % 2));

        // Reset while in EXEC discards the operation
        do_reset();
        id_hist.delete(); data_hist.delete();
        send(1, rand_fp(), rand_fp(), 20, 1'b1, ok1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(3);
        check("rst_exec_no_result", 32'(id_hist.size()), 32'd0);
        fork
            send(0, rand_fp(), rand_fp(), 20, 1'b1, ok0);
            send(1, rand_fp(), rand_fp(), 20, 1'b1, ok1);
        join
        wait_idle();
        check("rst_exec_grant", 32'(id_hist[0]), 32'(PRIO_INIT));

        // Withdrawn req1 pulse while in DONE
        do_reset();
        id_hist.delete(); data_hist.delete();
        res_ready = 1'b0;
        send(0, rand_fp(), rand_fp(), 20, 1'b1, ok0);
        cyc(1);
        req1_a = rand_fp(); req1_b = rand_fp(); req1_valid = 1'b1;
        cyc(1);
        req1_valid = 1'b0;
        cyc(2);
        res_ready = 1'b1;
        wait_idle();
        cyc(2);
        check("cancel_count", 32'(id_hist.size()), 32'd1);
        fork
            send(0, rand_fp(), rand_fp(), 20, 1'b1, ok0);
            send(1, rand_fp(), rand_fp(), 20, 1'b1, ok1);
        join
        wait_idle();
        check("cancel_next_grant", 32'(id_hist[1]), 32'd1);

        // Randomized traffic with withdrawals and backpressure
        do_reset();
        fork
            begin
                fork
                    for (int k = 0; k < 60; k++) begin
                        logic [31:0] a;
                        cyc(int'($urandom % 4));
                        a = rand_fp();
                        send(0, a, rand_b(a), 1 + int'($urandom % 8), 1'b0, ok0);
                    end
                    for (int k = 0; k < 60; k++) begin
                        logic [31:0] a;
                        cyc(int'($urandom % 4));
                        a = rand_fp();
                        send(1, a, rand_b(a), 1 + int'($urandom % 8), 1'b0, ok1);
                    end
                join
                rand_done = 1'b1;
            end
            while (!rand_done) begin
                res_ready = ($urandom % 4) != 0;
                cyc(1);
            end
        join
        res_ready = 1'b1;
        wait_idle();
        cyc(2);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
